// File: rtl/simon_pkg.sv
// simon_pkg: definitions shared by the Simon level-memory loader and reader.
//   colour_e        : 2-bit colour code stored in the level RAM
//   MAX_LEVEL       : longest sequence the level RAM can hold
//   LEVEL_ADDR_W    : level RAM address width
//   player_state_e  : sequence_player FSM states
package simon_pkg;

  localparam int unsigned MAX_LEVEL    = 8;
  localparam int unsigned LEVEL_ADDR_W = 3;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    BLUE   = 2'd2,
    YELLOW = 2'd3
  } colour_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_A,
    ST_FETCH_W,
    ST_SHOW,
    ST_GAP,
    ST_DONE
  } player_state_e;

endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter with a zero flag, shared by the SHOW
// and GAP phases of sequence_player.
//   clk        : system clock
//   reset      : synchronous, active-low reset (count -> 0)
//   load_i     : load load_val_i (takes priority over decrement)
//   load_val_i : value to load
//   en_i       : decrement by one while non-zero
//   zero_o     : count is zero
module phase_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/sequence_player.sv
// sequence_player: replays the stored Simon colour sequence for the current
// round. Reads steps 0..len-1 from a registered-read level RAM, shows each
// colour for ON_CYCLES with led_on high, then keeps dark for OFF_CYCLES.
//   clk       : system clock
//   reset     : synchronous, active-low reset
//   start     : request playback (sampled only in IDLE)
//   level     : steps to play, 0..8 (larger values clamp to 8)
//   mem_data  : colour from level RAM, valid one cycle after mem_addr
//   mem_addr  : level RAM read address
//   color_out : colour currently shown
//   led_on    : colour is being displayed
//   busy      : playback in progress
//   done      : one-cycle pulse at end of playback
// Optional feature macro SEQ_PLAYER_SPEEDUP_EN: halves the on-time for
// playbacks of 5 or more steps (minimum 1 cycle), chosen at start.
module sequence_player
  import simon_pkg::*;
#(
  parameter int unsigned ADDR_W     = LEVEL_ADDR_W,
  parameter int unsigned ON_CYCLES  = 25000000,
  parameter int unsigned OFF_CYCLES = 12500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   level,
  input  logic [1:0]        mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        color_out,
  output logic              led_on,
  output logic              busy,
  output logic              done
);

  localparam int unsigned TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0]     ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0]     OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [ADDR_W:0]   LEN_MAX  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] STEP_ONE = ADDR_W'(1);

  player_state_e     state_q, state_d;
  logic [ADDR_W-1:0] step_q, step_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  colour_e           color_q, color_d;
  logic              led_q, led_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [ADDR_W:0]   len_in;
  logic [ADDR_W:0]   last_step;
  logic [TW-1:0]     on_load;
  logic              t_load, t_en, t_zero;
  logic [TW-1:0]     t_val;

  assign len_in    = (level > LEN_MAX) ? LEN_MAX : level;
  assign last_step = len_q - LEN_ONE;

`ifdef SEQ_PLAYER_SPEEDUP_EN
  localparam int unsigned   ON_HALF   = ((ON_CYCLES >> 1) >= 1) ? (ON_CYCLES >> 1) : 1;
  localparam logic [TW-1:0] FAST_LOAD = TW'(ON_HALF - 1);
  localparam logic [ADDR_W:0] FAST_LEN = (ADDR_W+1)'(5);

  logic [TW-1:0] on_load_q, on_load_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      on_load_q <= '0;
    end else begin
      on_load_q <= on_load_d;
    end
  end

  always_comb begin
    on_load_d = on_load_q;
    if ((state_q == ST_IDLE) && start) begin
      on_load_d = (len_in >= FAST_LEN) ? FAST_LOAD : ON_LOAD;
    end
  end

  assign on_load = on_load_q;
`else
  assign on_load = ON_LOAD;
`endif

  phase_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (t_load),
    .load_val_i (t_val),
    .en_i       (t_en),
    .zero_o     (t_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      color_q <= RED;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      color_q <= color_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    len_d   = len_q;
    addr_d  = addr_q;
    color_d = color_q;
    led_d   = led_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    t_load  = 1'b0;
    t_val   = '0;
    t_en    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          len_d  = len_in;
          step_d = '0;
          if (len_in == '0) begin
            state_d = ST_DONE;
          end else begin
            addr_d  = '0;
            busy_d  = 1'b1;
            state_d = ST_FETCH_A;
          end
        end
      end
      ST_FETCH_A: state_d = ST_FETCH_W;
      ST_FETCH_W: begin
        color_d = colour_e'(mem_data);
        led_d   = 1'b1;
        t_load  = 1'b1;
        t_val   = on_load;
        state_d = ST_SHOW;
      end
      ST_SHOW: begin
        t_en = 1'b1;
        if (t_zero) begin
          led_d   = 1'b0;
          t_load  = 1'b1;
          t_val   = OFF_LOAD;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        t_en = 1'b1;
        if (t_zero) begin
          if ({1'b0, step_q} == last_step) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            step_d  = step_q + STEP_ONE;
            addr_d  = step_q + STEP_ONE;
            state_d = ST_FETCH_A;
          end
        end
      end
      ST_DONE: begin
        // Entered with done already set from GAP; an empty playback enters
        // with done clear, so it spends one extra cycle here raising it.
        if (done_q) begin
          state_d = ST_IDLE;
        end else begin
          done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_addr  = addr_q;
  assign color_out = color_q;
  assign led_on    = led_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/sequence_player.md
Name: sequence_player

Overview:
- Reader side of the level memory: replays the stored Simon colour sequence for the current round.
- Reads steps 0..level-1 from the level RAM one at a time.
- Shows each colour for a fixed on-time, followed by a dark gap.
- Sits between the level RAM and the LED/tone drivers; the game FSM starts it and waits for done.

Parameters:
- ADDR_W, 3, level RAM address width; maximum sequence length is 2^ADDR_W = 8.
- ON_CYCLES, 25000000, clock cycles each colour is shown (led_on high); must be >= 1.
- OFF_CYCLES, 12500000, clock cycles of dark gap after each colour; must be >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- start  input  1  request playback; sampled only in IDLE.
- level  input  ADDR_W+1  number of steps to play, 0..8; values above 8 are clamped to 8.
- mem_data  input  2  colour read from level RAM; valid one cycle after mem_addr is presented (registered-read RAM).
- mem_addr  output  ADDR_W  level RAM read address.
- color_out  output  2  colour currently being shown.
- led_on  output  1  high while color_out is being displayed.
- busy  output  1  high from start acceptance until the last gap ends.
- done  output  1  one-cycle pulse at the end of playback.

Behaviour:
- Reset:
  - reset==0 at a clk edge forces state IDLE.
  - mem_addr=0, color_out=0, led_on=0, busy=0, done=0, step counter=0, timer=0.
  - Reset mid-playback aborts immediately; no done pulse.
- All outputs are registered.
- Level capture: level is clamped to 8 and latched as len at start acceptance. Later changes to level are ignored until the next start.
- States: IDLE, FETCH_A, FETCH_W, SHOW, GAP, DONE.
- IDLE:
  - busy=0.
  - start==1 at edge T: latch len, step=0.
  - If len==0, go to DONE; otherwise mem_addr=0 and go to FETCH_A. busy=1 from T.
- FETCH_A: 1 cycle, address presented -> FETCH_W.
- FETCH_W: 1 cycle. At its closing edge: color_out<=mem_data, led_on<=1, timer<=ON_CYCLES-1, go to SHOW.
- SHOW:
  - Timer decrements each cycle.
  - At timer==0: led_on<=0, timer<=OFF_CYCLES-1, go to GAP.
  - led_on is high for exactly ON_CYCLES cycles.
- GAP:
  - Timer decrements each cycle; color_out holds its last value.
  - At timer==0, if step==len-1: go to DONE, busy<=0, done<=1.
  - Otherwise: step++, mem_addr<=step+1, go to FETCH_A.
- DONE: done=1 for exactly one cycle, then go to IDLE. A start during DONE is ignored.
- Timing: per step = 2+ON_CYCLES+OFF_CYCLES cycles. done is high in the cycle beginning at edge T + len*(2+ON_CYCLES+OFF_CYCLES); for len==0 it is T+1.
- start while busy or in DONE is ignored (no restart, no queueing).
- Width rules:
  - step is ADDR_W bits; len is ADDR_W+1 bits. The step==len-1 comparison uses ADDR_W+1 bits, so len=8 terminates at step 7 with no wrap.
  - Timer width is $clog2(max(ON_CYCLES,OFF_CYCLES)+1).

Optional Feature:
- Macro SEQ_PLAYER_SPEEDUP_EN.
- Defined: the on-time for a playback is ON_CYCLES>>1 when len>=5, and ON_CYCLES otherwise. This is decided at start acceptance. OFF_CYCLES is unchanged. The minimum on-time is 1 cycle.
- Undefined: on-time is always ON_CYCLES and no extra logic is generated.

Decomposition:
- Shared package simon_pkg:
  - Colour typedef, 2 bits (RED=0, GREEN=1, BLUE=2, YELLOW=3).
  - MAX_LEVEL=8 and LEVEL_ADDR_W=3 constants, also used by the loader side.
  - Player state enum.
- One natural sub-module, phase_timer: a loadable down-counter with a zero flag, used for both SHOW and GAP.

Test Plan (ON_CYCLES=4, OFF_CYCLES=2, RAM preloaded 0:RED,1:BLUE,2:GREEN,3:YELLOW..7):
- Reset: reset=0 for 2 cycles -> all outputs 0, state IDLE; start held during reset has no effect.
- level=3, start pulse at T:
  - mem_addr sequence 0,1,2.
  - color_out RED, BLUE, GREEN, each with led_on high for 4 cycles, then 2 cycles low.
  - done high only at T+24; busy high T..T+23.
- level=0, start -> done at T+1, led_on never asserted, busy low throughout.
- level=12 (clamped) -> exactly 8 colours played, addresses 0..7, done at T+64, no address wrap.
- start re-pulsed mid-playback and level changed to 1 during SHOW -> playback unaffected; done timing identical to the undisturbed run.
- reset=0 during GAP of step 2 -> next cycle IDLE, led_on=0, busy=0, no done pulse. A fresh start with level=1 then plays RED and is done at T+8. With SEQ_PLAYER_SPEEDUP_EN and level=5, the on-time is 2 cycles and done comes at T+30.
